sens_combiner: RTL and testbench
================================

SENS_COMBINER -- requirements
Module: sens_combiner

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand channel.
REQ-002 SHALL have parameter NCH, default 2: number of operand channels, legal range 2..8.
REQ-003 SHALL have parameter CNTW, default 8: width of the event and coalesce counters.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port in_data, input, NCH*WIDTH: operand channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port mode, input, 2: reduction operator. 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 Port out_data, output, WIDTH: registered reduction result.
REQ-009 Port out_valid, output, 1: out_data holds an undelivered result.
REQ-010 Port out_ready, input, 1: consumer accepts out_data when out_valid && out_ready at a clock edge.
REQ-011 Port evt_count, output, CNTW: number of trigger events since reset; saturating.
REQ-012 Port coalesce_count, output, CNTW: number of results overwritten before delivery; saturating.

Function
REQ-013 SHALL hold snapshot registers of the last-sampled in_data and mode.
REQ-014 A trigger SHALL occur at an edge when in_data != snapshot or mode != mode snapshot; this models an @(a or b ...) sensitivity list, with mode added to the list.
REQ-015 On a trigger, the snapshots SHALL load the current in_data and mode at the same edge.
REQ-016 The result SHALL be the bitwise reduction across all NCH channels using the current mode; NAND is the inverted AND of all channels.
REQ-017 Latency: inputs stable before edge k that cause a trigger SHALL produce out_data and out_valid = 1 visible after edge k (one edge).
REQ-018 The FSM SHALL have two states:
  - IDLE: out_valid = 0.
  - HOLD: out_valid = 1.
REQ-019 In IDLE, a trigger SHALL move the FSM to HOLD and load out_data.
REQ-020 In HOLD, out_valid && out_ready with no trigger SHALL return the FSM to IDLE; out_data keeps its value.
REQ-021 In HOLD, a trigger without out_ready SHALL overwrite out_data (latest wins), keep HOLD, and increment coalesce_count.
REQ-022 In HOLD, a trigger together with out_ready SHALL deliver the old result, load the new one, keep out_valid = 1, and not increment coalesce_count.
REQ-023 Every trigger SHALL increment evt_count, saturating at 2^CNTW-1.
REQ-024 coalesce_count SHALL saturate at 2^CNTW-1.
REQ-025 With no trigger, out_data and out_valid SHALL remain stable regardless of out_ready toggling, except as stated in REQ-020.

Reset
REQ-026 When rst_n = 0 at an edge, the block SHALL set: FSM to IDLE, out_valid = 0, out_data = 0, evt_count = 0, coalesce_count = 0, in_data snapshot = 0, mode snapshot = 00.
REQ-027 Reset asserted mid-HOLD SHALL discard the pending result; no delivery occurs at that edge.
REQ-028 At the first edge after reset release, nonzero in_data or nonzero mode SHALL count as a trigger.

Structure
REQ-029 A shared package SHALL hold the mode encodings (MODE_AND, MODE_OR, MODE_XOR, MODE_NAND) and the FSM state type/constants (ST_IDLE, ST_HOLD).
REQ-030 The block SHALL contain one combinational sub-module, sens_reduce (parameters WIDTH and NCH; inputs in_data and mode; output result), instantiated once.
REQ-031 All other logic SHALL be in sens_combiner.

Verification
REQ-032 NCH=2, WIDTH=8, mode=AND, in_data {0F,FF} applied after reset, out_ready=1 -> out_data=0F and out_valid=1 one edge later; evt_count=1.
REQ-033 Hold inputs constant for 10 cycles after delivery -> out_valid stays 0 and evt_count stays 1.
REQ-034 out_ready=0; change to mode=XOR, then to mode=OR on the next cycle -> out_data=FF, coalesce_count=1, evt_count=3.
REQ-035 In HOLD, change inputs to {00,F0} with mode=AND in the same cycle as out_ready=1 -> old value delivered, out_data=00, out_valid=1, coalesce_count unchanged.
REQ-036 CNTW=2, apply 5 distinct input changes -> evt_count saturates at 3.
REQ-037 Assert rst_n=0 while in HOLD -> after the edge: out_valid=0, all counters 0; reapply the same in_data -> trigger and result re-emitted.

Source files
------------

// File: rtl/sens_combiner_pkg.sv
// Shared definitions for the sensitivity-list combiner: reduction operator
// encodings and the output-holding FSM state type.
package sens_combiner_pkg;

  // Reduction operator selected by the mode input.
  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  // IDLE: nothing to deliver. HOLD: out_data carries an undelivered result.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage : sens_combiner_pkg

// File: rtl/sens_reduce.sv
// Purely combinational bitwise reduction of NCH operand channels using the
// operator selected by mode. Channel i lives at in_data[i*WIDTH +: WIDTH].
module sens_reduce
  import sens_combiner_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     result
);

  // Running reductions: element gi+1 folds channel gi into element gi.
  logic [NCH:0][WIDTH-1:0] and_chain;
  logic [NCH:0][WIDTH-1:0] or_chain;
  logic [NCH:0][WIDTH-1:0] xor_chain;

  assign and_chain[0] = '1;
  assign or_chain[0]  = '0;
  assign xor_chain[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign and_chain[gi+1] = and_chain[gi] & in_data[gi*WIDTH +: WIDTH];
      assign or_chain[gi+1]  = or_chain[gi]  | in_data[gi*WIDTH +: WIDTH];
      assign xor_chain[gi+1] = xor_chain[gi] ^ in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pick the fully folded value for the requested operator.
  always_comb begin
    result = and_chain[NCH];
    case (mode)
      MODE_AND:  result = and_chain[NCH];
      MODE_OR:   result = or_chain[NCH];
      MODE_XOR:  result = xor_chain[NCH];
      MODE_NAND: result = ~and_chain[NCH];
      default:   result = and_chain[NCH];
    endcase
  end

endmodule : sens_reduce

// File: rtl/sens_combiner.sv
// Models an @(in_data or mode) sensitivity list in synchronous logic: any
// change against the last-sampled snapshot is a trigger that recomputes the
// reduction into a one-deep valid/ready output register. Unread results are
// overwritten (latest wins) and counted as coalesced. NCH must be 2..8.
module sens_combiner
  import sens_combiner_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      evt_count,
  output logic [CNTW-1:0]      coalesce_count
);

  state_t               state_q, state_d;
  logic [NCH*WIDTH-1:0] snap_data_q, snap_data_d;
  logic [1:0]           snap_mode_q, snap_mode_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNTW-1:0]      evt_q, evt_d;
  logic [CNTW-1:0]      coal_q, coal_d;

  logic                 trigger;
  logic [WIDTH-1:0]     result;

  sens_reduce #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_reduce (
    .in_data (in_data),
    .mode    (mode),
    .result  (result)
  );

  // A trigger is any difference between the live inputs and the snapshot.
  assign trigger = (in_data != snap_data_q) || (mode != snap_mode_q);

  // Next-state logic: snapshots, event counter, FSM, output data, coalescing.
  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    snap_mode_d = snap_mode_q;
    data_d      = data_q;
    evt_d       = evt_q;
    coal_d      = coal_q;

    if (trigger) begin
      snap_data_d = in_data;
      snap_mode_d = mode;
      if (evt_q != '1) begin
        evt_d = evt_q + CNTW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_HOLD;
          data_d  = result;
        end
      end
      ST_HOLD: begin
        if (trigger) begin
          // With out_ready the old value leaves this edge, so nothing is lost.
          data_d = result;
          if (!out_ready && (coal_q != '1)) begin
            coal_d = coal_q + CNTW'(1);
          end
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pending result without delivering it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snap_data_q <= '0;
      snap_mode_q <= MODE_AND;
      data_q      <= '0;
      evt_q       <= '0;
      coal_q      <= '0;
    end else begin
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
      snap_mode_q <= snap_mode_d;
      data_q      <= data_d;
      evt_q       <= evt_d;
      coal_q      <= coal_d;
    end
  end

  assign out_data       = data_q;
  assign out_valid      = (state_q == ST_HOLD);
  assign evt_count      = evt_q;
  assign coalesce_count = coal_q;

endmodule : sens_combiner

// File: tb/tb_sens_combiner.sv
// Directed bench for sens_combiner. Stimulus pushes the hand-computed value
// expected at each delivery into a queue; a monitor pops and compares on
// every out_valid && out_ready handshake. Counters and state are checked
// directly. A second instance with CNTW=2 covers counter saturation.
module tb_sens_combiner;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  evt_count;
  logic [7:0]  coalesce_count;

  logic        rst_n_b;
  logic [15:0] in_data_b;
  logic [1:0]  mode_b;
  logic [7:0]  out_data_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [1:0]  evt_count_b;
  logic [1:0]  coalesce_count_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  sens_combiner #(.WIDTH(8), .NCH(2), .CNTW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .mode           (mode),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .evt_count      (evt_count),
    .coalesce_count (coalesce_count)
  );

  sens_combiner #(.WIDTH(8), .NCH(2), .CNTW(2)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n_b),
    .in_data        (in_data_b),
    .mode           (mode_b),
    .out_data       (out_data_b),
    .out_valid      (out_valid_b),
    .out_ready      (out_ready_b),
    .evt_count      (evt_count_b),
    .coalesce_count (coalesce_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Delivery monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL deliver: got %0h expected no delivery", out_data);
      end else begin
        logic [7:0] exp_v;
        exp_v = sb.pop_front();
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL deliver: got %0h expected %0h", out_data, exp_v);
        end else begin
          $display("ok   deliver: %0h", out_data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_data = '0; mode = 2'b00; out_ready = 1'b0;
    rst_n_b = 1'b0; in_data_b = '0; mode_b = 2'b00; out_ready_b = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_evt", 32'(evt_count), 32'h0);
    check("rst_coal", 32'(coalesce_count), 32'h0);

    // Zero inputs match the reset snapshot: no trigger.
    rst_n = 1'b1;
    tick();
    check("idle_no_trig_valid", 32'(out_valid), 32'h0);
    check("idle_no_trig_evt", 32'(evt_count), 32'h0);

    // AND of {0F,FF} = 0F, visible one edge later, delivered with ready=1.
    in_data = {8'h0F, 8'hFF}; mode = 2'b00; out_ready = 1'b1;
    sb.push_back(8'h0F);
    tick();
    check("and_valid", 32'(out_valid), 32'h1);
    check("and_data", 32'(out_data), 32'h0F);
    check("and_evt", 32'(evt_count), 32'h1);
    tick();
    check("and_delivered_valid", 32'(out_valid), 32'h0);

    // Stable inputs: no retrigger.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stable_valid", 32'(out_valid), 32'h0);
      check("stable_evt", 32'(evt_count), 32'h1);
    end

    // XOR then OR without ready: the XOR result (F0) is overwritten by FF.
    out_ready = 1'b0; mode = 2'b10;
    tick();
    check("xor_data", 32'(out_data), 32'hF0);
    check("xor_valid", 32'(out_valid), 32'h1);
    mode = 2'b01;
    tick();
    check("or_data", 32'(out_data), 32'hFF);
    check("or_coal", 32'(coalesce_count), 32'h1);
    check("or_evt", 32'(evt_count), 32'h3);

    // Trigger with ready in HOLD: FF leaves, AND of {00,F0} = 00 loaded.
    sb.push_back(8'hFF);
    sb.push_back(8'h00);
    in_data = {8'h00, 8'hF0}; mode = 2'b00; out_ready = 1'b1;
    tick();
    check("swap_data", 32'(out_data), 32'h00);
    check("swap_valid", 32'(out_valid), 32'h1);
    check("swap_coal", 32'(coalesce_count), 32'h1);
    check("swap_evt", 32'(evt_count), 32'h4);
    tick();
    check("swap_drain_valid", 32'(out_valid), 32'h0);

    // Enter HOLD with OR of {3C,5A} = 7E, then reset (ready high) discards it.
    out_ready = 1'b0; in_data = {8'h3C, 8'h5A}; mode = 2'b01;
    tick();
    check("pre_rst_data", 32'(out_data), 32'h7E);
    check("pre_rst_evt", 32'(evt_count), 32'h5);
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_evt", 32'(evt_count), 32'h0);
    check("mid_rst_coal", 32'(coalesce_count), 32'h0);

    // Same inputs after release differ from the cleared snapshot: re-emitted.
    rst_n = 1'b1; out_ready = 1'b0;
    tick();
    check("reemit_valid", 32'(out_valid), 32'h1);
    check("reemit_data", 32'(out_data), 32'h7E);
    check("reemit_evt", 32'(evt_count), 32'h1);
    sb.push_back(8'h7E);
    out_ready = 1'b1;
    tick();
    check("reemit_drain_valid", 32'(out_valid), 32'h0);

    // NAND of {0F,FF} = F0; held steady while the consumer stalls.
    out_ready = 1'b0; in_data = {8'h0F, 8'hFF}; mode = 2'b11;
    tick();
    check("nand_data", 32'(out_data), 32'hF0);
    check("nand_evt", 32'(evt_count), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_data", 32'(out_data), 32'hF0);
      check("stall_coal", 32'(coalesce_count), 32'h0);
    end
    sb.push_back(8'hF0);
    out_ready = 1'b1;
    tick();
    check("nand_drain_valid", 32'(out_valid), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    // CNTW=2 instance: evt saturates at 3, then coalesce saturates at 3.
    rst_n_b = 1'b1; out_ready_b = 1'b1; mode_b = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      in_data_b = {8'h00, 8'(k)};
      tick();
      check("sat_evt", 32'(evt_count_b), (k > 3) ? 32'd3 : 32'(k));
      check("sat_coal_zero", 32'(coalesce_count_b), 32'h0);
    end
    check("sat_valid", 32'(out_valid_b), 32'h1);
    out_ready_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_data_b = {8'h10, 8'(k)};
      tick();
      check("sat_coal", 32'(coalesce_count_b), (k > 3) ? 32'd3 : 32'(k));
      check("sat_evt_hold", 32'(evt_count_b), 32'd3);
    end
    check("sat_data", 32'(out_data_b), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sens_combiner
